sobel_window: RTL and testbench

Streaming front end of the Sobel edge pipeline. It accepts one 8-bit grayscale pixel per valid cycle in raster order and buffers the two previous image lines. It forms a 3x3 window and emits the horizontal and vertical gradient magnitudes (gx, gy) for every interior pixel. Its outputs feed total_gradient directly: gx/gy connect to its inputs, and grad_valid qualifies them.

---
 rtl/sobel_window.sv | 116 +++++++++++
 tb/tb_sobel_window.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window.sv
// Streaming 3x3 Sobel front end: two line buffers feed a sliding window,
// and registered |Gx|>>2 / |Gy|>>2 are emitted for every interior pixel.
module sobel_window #(
   parameter int IMG_WIDTH = 64
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [7:0] pixel_in,
   input  logic       pixel_valid,
   input  logic       frame_start,
   output logic [7:0] gx,
   output logic [7:0] gy,
   output logic       grad_valid
);

   localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

   state_t            state;
   logic [COL_W-1:0]  col;
   logic [1:0]        row;
   logic [7:0]        line0 [IMG_WIDTH];
   logic [7:0]        line1 [IMG_WIDTH];
   logic [7:0]        win   [3][3];
   logic [7:0]        nwin  [3][3];

   logic              restart;
   logic              accept;
   logic              last_col;
   logic              out_en;
   logic [COL_W-1:0]  idx;
   logic signed [10:0] gx_s;
   logic signed [10:0] gy_s;

   function automatic logic signed [10:0] px(input logic [7:0] p);
      return $signed({3'b000, p});
   endfunction

   function automatic logic [7:0] mag(input logic signed [10:0] g);
      logic signed [10:0] a;
      a = (g < 0) ? -g : g;
      return 8'(a >>> 2);
   endfunction

   assign restart  = pixel_valid & frame_start;
   assign accept   = pixel_valid & (frame_start | (state != IDLE));
   assign last_col = (col == LAST_COL);
   // A restarting pixel is always column 0, whatever col held before.
   assign idx      = restart ? '0 : col;
   assign out_en   = accept & ~restart & (state == RUN) & (col >= COL_W'(2));

   always_comb begin
      for (int r = 0; r < 3; r++) begin
         nwin[r][0] = win[r][1];
         nwin[r][1] = win[r][2];
      end
      nwin[0][2] = line0[idx];
      nwin[1][2] = line1[idx];
      nwin[2][2] = pixel_in;
   end

   always_comb begin
      gx_s = (px(nwin[0][2]) + (px(nwin[1][2]) <<< 1) + px(nwin[2][2]))
           - (px(nwin[0][0]) + (px(nwin[1][0]) <<< 1) + px(nwin[2][0]));
      gy_s = (px(nwin[2][0]) + (px(nwin[2][1]) <<< 1) + px(nwin[2][2]))
           - (px(nwin[0][0]) + (px(nwin[0][1]) <<< 1) + px(nwin[0][2]));
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         line0[idx] <= line1[idx];
         line1[idx] <= pixel_in;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= IDLE;
         row        <= 2'd0;
         col        <= '0;
         grad_valid <= 1'b0;
         gx         <= 8'd0;
         gy         <= 8'd0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               win[r][c] <= 8'd0;
      end else begin
         grad_valid <= out_en;
         if (out_en) begin
            gx <= mag(gx_s);
            gy <= mag(gy_s);
         end
         if (accept) begin
            for (int r = 0; r < 3; r++)
               for (int c = 0; c < 3; c++)
                  win[r][c] <= nwin[r][c];
            if (restart) begin
               state <= FILL;
               row   <= 2'd0;
               col   <= COL_W'(1);
            end else if (last_col) begin
               col <= '0;
               if (row != 2'd2)
                  row <= row + 2'd1;
               if (state == FILL && row == 2'd1)
                  state <= RUN;
            end else begin
               col <= col + COL_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_sobel_window.sv
// Scoreboard bench for sobel_window: expected gradients come from a direct
// 3x3 convolution over the image the bench drives.
module tb_sobel_window;

   localparam int W = 4;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic [7:0] pixel_in = 8'd0;
   logic       pixel_valid = 1'b0;
   logic       frame_start = 1'b0;
   logic [7:0] gx;
   logic [7:0] gy;
   logic       grad_valid;

   typedef struct {
      int egx;
      int egy;
      int ecyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   img [3][W];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   pulses = 0;
   int   base;

   always #5 clk = ~clk;

   sobel_window #(.IMG_WIDTH(W)) dut (
      .clk(clk),
      .n_rst(n_rst),
      .pixel_in(pixel_in),
      .pixel_valid(pixel_valid),
      .frame_start(frame_start),
      .gx(gx),
      .gy(gy),
      .grad_valid(grad_valid)
   );

   task automatic checkOutput(input string tag, input int observed, input int expected);
      vectors++;
      if (observed != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   function automatic int grad(input int r, input int c, input bit vert);
      int a, b;
      if (!vert) begin
         a = img[r-2][c]   + 2*img[r-1][c]   + img[r][c];
         b = img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2];
      end else begin
         a = img[r][c-2]   + 2*img[r][c-1]   + img[r][c];
         b = img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c];
      end
      return ((a >= b) ? a - b : b - a) >> 2;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Every pulse must match the oldest outstanding expectation, on time.
   always @(posedge clk) begin
      #1;
      if (grad_valid === 1'b1) begin
         pulses++;
         if (sb.size() == 0) begin
            checkOutput("unexpected_pulse", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            checkOutput("gx", int'(gx), mon_e.egx);
            checkOutput("gy", int'(gy), mon_e.egy);
            checkOutput("latency", cyc, mon_e.ecyc);
         end
      end
   end

   task automatic applyStimulus(input int npix, input int gap);
      int r, c;
      exp_t e;
      for (int i = 0; i < npix; i++) begin
         r = i / W;
         c = i % W;
         @(negedge clk);
         pixel_in    = 8'(img[r][c]);
         pixel_valid = 1'b1;
         frame_start = (i == 0);
         if (r >= 2 && c >= 2) begin
            e.egx  = grad(r, c, 1'b0);
            e.egy  = grad(r, c, 1'b1);
            e.ecyc = cyc + 1;
            sb.push_back(e);
         end
         repeat (gap) begin
            @(negedge clk);
            pixel_valid = 1'b0;
            frame_start = 1'b0;
            pixel_in    = 8'hAA;
         end
      end
      @(negedge clk);
      pixel_valid = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         pixel_valid = 1'b0;
         frame_start = 1'b0;
      end
   endtask

   task automatic fill_img(input int mode);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < W; c++)
            case (mode)
               0: img[r][c] = (c >= 2) ? 255 : 0;
               1: img[r][c] = (r == 0) ? 255 : 0;
               2: img[r][c] = 4 * c;
               default: img[r][c] = 100;
            endcase
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (3) @(negedge clk);
      checkOutput("reset_gx", int'(gx), 0);
      checkOutput("reset_gy", int'(gy), 0);
      checkOutput("reset_valid", int'(grad_valid), 0);
      n_rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         pixel_in    = 8'(i * 20 + 5);
         pixel_valid = 1'b1;
         frame_start = 1'b0;
      end
      idle(4);
      checkOutput("idle_pulses", pulses, 0);
      checkOutput("idle_gx", int'(gx), 0);

      $display("[TB] vertical edge");
      fill_img(0);
      base = pulses;
      applyStimulus(3 * W, 0);
      idle(4);
      checkOutput("vert_count", pulses - base, 2);
      checkOutput("vert_hold_gx", int'(gx), 255);
      checkOutput("vert_hold_gy", int'(gy), 0);

      $display("[TB] horizontal edge");
      fill_img(1);
      base = pulses;
      applyStimulus(3 * W, 0);
      idle(4);
      checkOutput("horiz_count", pulses - base, 2);
      checkOutput("horiz_gy", int'(gy), 255);

      $display("[TB] ramp with gaps");
      fill_img(2);
      base = pulses;
      applyStimulus(3 * W, 1);
      idle(4);
      checkOutput("ramp_count", pulses - base, 2);
      checkOutput("ramp_gx", int'(gx), 8);

      $display("[TB] frame restart");
      base = pulses;
      applyStimulus(2 * W + 2, 0);
      fill_img(3);
      applyStimulus(3 * W, 0);
      idle(4);
      checkOutput("restart_count", pulses - base, 2);
      checkOutput("restart_gx", int'(gx), 0);

      $display("[TB] reset mid-run");
      fill_img(0);
      base = pulses;
      applyStimulus(2 * W + 3, 0);
      checkOutput("prereset_valid", int'(grad_valid), 1);
      n_rst = 1'b0;
      #1;
      checkOutput("rst_async_valid", int'(grad_valid), 0);
      checkOutput("rst_async_gx", int'(gx), 0);
      @(negedge clk);
      n_rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         pixel_in    = 8'(i * 40);
         pixel_valid = 1'b1;
         frame_start = 1'b0;
      end
      idle(4);
      checkOutput("postreset_count", pulses - base, 1);
      applyStimulus(3 * W, 0);
      idle(4);
      checkOutput("newframe_count", pulses - base, 3);
      checkOutput("sb_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
